// File: rtl/fp_mul_round_pack.sv
// FP32 multiply back end: normalises the raw significand product, rounds to nearest-even
// and packs an IEEE-754 word through a two-stage valid/ready pipeline (subnormals flush to zero).
module fp_mul_round_pack #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*FRAC_W+1:0]         in_prod,
    input  logic                        in_sign,
    input  logic [EXP_W+1:0]            in_exp,
    input  logic                        in_nan,
    input  logic                        in_inf,
    input  logic                        in_zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+FRAC_W:0]       out_result,
    output logic [2:0]                  out_flags
);

    localparam int PW    = 2 * (FRAC_W + 1);
    localparam int EW    = EXP_W + 3;
    localparam int RES_W = 1 + EXP_W + FRAC_W;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

    // Returns {carry, rounded fraction}; a carry leaves the fraction at zero.
    function automatic logic [FRAC_W:0] round_rne(input logic [FRAC_W-1:0] m,
                                                  input logic g, input logic st);
        logic inc;
        inc = g & (st | m[0]);
        return {1'b0, m} + {{FRAC_W{1'b0}}, inc};
    endfunction

    logic run;
    logic vld_p1, vld_p2;
    logic s1_adv, s2_adv;

    assign s2_adv    = !vld_p2 | out_ready;
    assign s1_adv    = run & (!vld_p1 | s2_adv);
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run    <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            run <= 1'b1;
            if (s1_adv) vld_p1 <= in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: normalise ----
    logic [FRAC_W-1:0]     m_n;
    logic                  g_n, st_n;
    logic signed [EW-1:0]  e_ext, e_n;

    assign e_ext = {in_exp[EXP_W+1], in_exp};

    always_comb begin
        m_n  = in_prod[PW-3 -: FRAC_W];
        g_n  = in_prod[PW-3-FRAC_W];
        st_n = |in_prod[PW-4-FRAC_W:0];
        e_n  = e_ext;
        if (in_prod[PW-1]) begin
            m_n  = in_prod[PW-2 -: FRAC_W];
            g_n  = in_prod[PW-2-FRAC_W];
            st_n = |in_prod[PW-3-FRAC_W:0];
            e_n  = e_ext + ONE_E;
        end
    end

    logic [FRAC_W-1:0]     m_p1;
    logic                  g_p1, st_p1, sign_p1, nan_p1, inf_p1, zero_p1;
    logic signed [EW-1:0]  e_p1;

    always_ff @(posedge clk) begin
        if (s1_adv) begin
            m_p1    <= m_n;
            g_p1    <= g_n;
            st_p1   <= st_n;
            e_p1    <= e_n;
            sign_p1 <= in_sign;
            nan_p1  <= in_nan;
            inf_p1  <= in_inf;
            zero_p1 <= in_zero;
        end
    end

    // ---- stage 2: round and pack ----
    logic [FRAC_W:0]       rsum;
    logic [FRAC_W-1:0]     m_r;
    logic signed [EW-1:0]  e_r;
    logic                  inexact;
    logic [RES_W-1:0]      res_n;
    logic [2:0]            flags_n;

    always_comb begin
        rsum    = round_rne(m_p1, g_p1, st_p1);
        m_r     = rsum[FRAC_W-1:0];
        e_r     = rsum[FRAC_W] ? e_p1 + ONE_E : e_p1;
        inexact = g_p1 | st_p1;
        res_n   = {sign_p1, e_r[EXP_W-1:0], m_r};
        flags_n = {2'b00, inexact};
        if (nan_p1) begin
            res_n   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            flags_n = 3'b000;
        end else if (inf_p1) begin
            res_n   = {sign_p1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_n = 3'b000;
        end else if (zero_p1) begin
            res_n   = {sign_p1, {(RES_W-1){1'b0}}};
            flags_n = 3'b000;
        end else if (e_r >= EMAX_E) begin
            res_n   = {sign_p1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_n = 3'b101;
        end else if (e_r <= ZERO_E) begin
            res_n   = {sign_p1, {(RES_W-1){1'b0}}};
            flags_n = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_adv) begin
            out_result <= res_n;
            out_flags  <= flags_n;
        end
    end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed bench for fp_mul_round_pack: reset, rounding, specials, range limits,
// backpressure and mid-stream reset.
module tb_fp_mul_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_prod;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic        in_nan, in_inf, in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_mul_round_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_sign(in_sign), .in_exp(in_exp),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [47:0] p, input logic s, input logic [9:0] e,
                         input logic nan, input logic inf, input logic zero);
        in_prod = p; in_sign = s; in_exp = e;
        in_nan = nan; in_inf = inf; in_zero = zero;
    endtask

    // Single beat with out_ready held high: accepted on edge 1, visible after edge 2.
    task automatic run_vec(input string tag, input logic [47:0] p, input logic s,
                           input logic [9:0] e, input logic nan, input logic inf,
                           input logic zero, input logic [31:0] res, input logic [2:0] fl);
        @(negedge clk);
        drive(p, s, e, nan, inf, zero);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_res"}, out_result, res);
        check({tag, "_flg"}, out_flags, fl);
    endtask

    function automatic logic [31:0] beat_res(input int i);
        logic [7:0] e8;
        e8 = 8'(100 + i);
        return {1'(i % 2), e8, 23'd0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, j, stale;
        logic [31:0] held;
        logic acc, emit;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(48'h0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_res", out_result, 0);
        check("rst_flg", out_flags, 0);
        rst = 1'b1;
        #1 check("rel_rdy_pre", in_ready, 0);
        @(negedge clk);
        check("rel_rdy_post", in_ready, 1);

        // Normal values and rounding
        run_vec("one",      48'h400000000000, 0, 10'd127, 0, 0, 0, 32'h3F800000, 3'b000);
        run_vec("sq15",     48'h900000000000, 0, 10'd127, 0, 0, 0, 32'h40100000, 3'b000);
        run_vec("sq15neg",  48'h900000000000, 1, 10'd127, 0, 0, 0, 32'hC0100000, 3'b000);
        run_vec("tie_even", 48'h400000400000, 0, 10'd127, 0, 0, 0, 32'h3F800000, 3'b001);
        run_vec("tie_odd",  48'h400000C00000, 0, 10'd127, 0, 0, 0, 32'h3F800002, 3'b001);
        run_vec("above",    48'h400000400001, 0, 10'd127, 0, 0, 0, 32'h3F800001, 3'b001);
        run_vec("below",    48'h4000003FFFFF, 0, 10'd127, 0, 0, 0, 32'h3F800000, 3'b001);
        run_vec("carry",    48'h7FFFFFC00000, 0, 10'd127, 0, 0, 0, 32'h40000000, 3'b001);

        // Exponent range limits
        run_vec("max_norm", 48'h400000000000, 0, 10'd254, 0, 0, 0, 32'h7F000000, 3'b000);
        run_vec("ovf",      48'h800000000000, 0, 10'd254, 0, 0, 0, 32'h7F800000, 3'b101);
        run_vec("ovf_rnd",  48'h7FFFFFC00000, 1, 10'd254, 0, 0, 0, 32'hFF800000, 3'b101);
        run_vec("min_norm", 48'h400000000000, 0, 10'd1,   0, 0, 0, 32'h00800000, 3'b000);
        run_vec("unf",      48'h400000000000, 0, 10'd0,   0, 0, 0, 32'h00000000, 3'b011);
        run_vec("unf_neg",  48'h400000000000, 1, 10'h3F6, 0, 0, 0, 32'h80000000, 3'b011);

        // Specials
        run_vec("nan_all",  48'h900000000000, 1, 10'd300, 1, 1, 1, 32'h7FC00000, 3'b000);
        run_vec("inf_neg",  48'h400000000000, 1, 10'd127, 0, 1, 0, 32'hFF800000, 3'b000);
        run_vec("zero_neg", 48'h400000000000, 1, 10'd127, 0, 0, 1, 32'h80000000, 3'b000);

        // Backpressure: out_ready low for the first 4 cycles of a 5-beat stream
        k = 0; j = 0; held = '0;
        @(negedge clk);
        for (int c = 0; c < 30 && j < 5; c++) begin
            out_ready = (c >= 4);
            in_valid  = (k < 5);
            drive(48'h400000000000, 1'(k % 2), 10'(100 + k), 0, 0, 0);
            #1;
            if (c == 2) begin
                check("bp_accepted", k, 2);
                check("bp_rdy2", in_ready, 0);
                held = out_result;
            end
            if (c == 3) begin
                check("bp_rdy3", in_ready, 0);
                check("bp_vld3", out_valid, 1);
                check("bp_hold", out_result, held);
            end
            acc  = in_valid & in_ready;
            emit = out_valid & out_ready;
            if (emit) begin
                check($sformatf("bp_beat%0d", j), out_result, beat_res(j));
                j++;
            end
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_all_out", j, 5);
        check("bp_all_in", k, 5);

        // Reset while beats are in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(48'h900000000000, 0, 10'd127, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("mid_vld_pre", out_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_vld", out_valid, 0);
        check("mid_res", out_result, 0);
        check("mid_rdy", in_ready, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_stale", stale, 0);
        run_vec("post_rst", 48'h400000000000, 0, 10'd127, 0, 0, 0, 32'h3F800000, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
